// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package rf_writeback_arbiter_pkg;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned NUM_REGS     = 1 << ADDR_W_DEF;
  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned MAX_WAIT_MIN = 1;
  localparam int unsigned MAX_WAIT_MAX = 15;
  localparam int unsigned WAIT_CNT_W   = 4;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MDU = 1'b1
  } pri_e;
endpackage

// File: rtl/rf_wb_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, set on MDU issue,
// cleared on MDU write-back; a same-cycle set overrides the clear. Bit 0 is tied low.
module rf_wb_scoreboard
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_set_en,
  input  logic [ADDR_W-1:0]      i_set_rd,
  input  logic                   i_clr_en,
  input  logic [ADDR_W-1:0]      i_clr_rd,
  output logic [2**ADDR_W-1:0]   o_busy_vec
);
  logic [2**ADDR_W-1:0] r_busy;
  logic [2**ADDR_W-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_rd] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_rd] = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  assign o_busy_vec = r_busy;
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and MDU results onto the register file's single write port with
// starvation-bounded ALU priority. Optional macro RFWB_ERR_CHECK_EN adds err_sticky.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [ADDR_W-1:0]    mdu_rd,
  input  logic [DATA_W-1:0]    mdu_data,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata
`ifdef RFWB_ERR_CHECK_EN
  ,
  output logic                 err_sticky
`endif
);
  if (MAX_WAIT < MAX_WAIT_MIN || MAX_WAIT > MAX_WAIT_MAX) begin : g_bad_max_wait
    $error("rf_writeback_arbiter: MAX_WAIT out of range 1..15");
  end

  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  w_starve;
  pri_e                  w_pri;
  logic                  w_alu_xfer;
  logic                  w_mdu_xfer;

  assign w_starve = (r_wait_cnt == WAIT_CNT_W'(MAX_WAIT));
  assign w_pri    = w_starve ? PRI_MDU : PRI_ALU;

  // Ready depends only on the valids and the starve flag, never on rd/data.
  always_comb begin
    alu_ready = 1'b1;
    mdu_ready = !alu_valid;
    if (w_pri == PRI_MDU) begin
      mdu_ready = 1'b1;
      alu_ready = !mdu_valid;
    end
  end

  assign w_alu_xfer = alu_valid && alu_ready;
  assign w_mdu_xfer = mdu_valid && mdu_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (!mdu_valid || w_mdu_xfer) begin
      r_wait_cnt <= '0;
    end else if (!w_starve) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w_alu_xfer) begin
      rf_we    <= (alu_rd != '0);
      rf_waddr <= alu_rd;
      rf_wdata <= alu_data;
    end else if (w_mdu_xfer) begin
      rf_we    <= (mdu_rd != '0);
      rf_waddr <= mdu_rd;
      rf_wdata <= mdu_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  rf_wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_set_en   (issue_valid),
    .i_set_rd   (issue_rd),
    .i_clr_en   (w_mdu_xfer),
    .i_clr_rd   (mdu_rd),
    .o_busy_vec (busy_vec)
  );

`ifdef RFWB_ERR_CHECK_EN
  logic w_err_mdu;
  logic w_err_alu;

  // Uses busy_vec as it stood before the edge that performs the transfer.
  assign w_err_mdu = w_mdu_xfer && (mdu_rd != '0) && !busy_vec[mdu_rd];
  assign w_err_alu = w_alu_xfer && busy_vec[alu_rd];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       err_sticky <= 1'b0;
    else if (w_err_mdu || w_err_alu)  err_sticky <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed plus randomized bench for rf_writeback_arbiter against a behavioural model.
module tb_rf_writeback_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;
  localparam int unsigned MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mdu_valid, mdu_ready;
  logic [AW-1:0] mdu_rd;
  logic [DW-1:0] mdu_data;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic [NR-1:0] busy_vec;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef RFWB_ERR_CHECK_EN
  logic          err_sticky;
`endif

  rf_writeback_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_WAIT (MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_rd      (mdu_rd),
    .mdu_data    (mdu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_vec    (busy_vec),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
`ifdef RFWB_ERR_CHECK_EN
    ,
    .err_sticky  (err_sticky)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  int            m_wait;
  bit            m_busy [NR];
  bit            m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_err;
  bit            last_ax, last_mx;

  function automatic logic [NR-1:0] busy_word();
    logic [NR-1:0] w;
    for (int i = 0; i < NR; i++) w[i] = m_busy[i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait  = 0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_err   = 1'b0;
    last_ax = 1'b0;
    last_mx = 1'b0;
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mdu_valid = 0; mdu_rd = '0; mdu_data = '0;
    issue_valid = 0; issue_rd = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_we"},    64'(rf_we),    64'(m_we));
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(m_waddr));
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'(m_wdata));
    chk({tag, "_busy"},  64'(busy_vec), 64'(busy_word()));
`ifdef RFWB_ERR_CHECK_EN
    chk({tag, "_err"},   64'(err_sticky), 64'(m_err));
`endif
  endtask

  // One clock: check readies against the arbitration rules, then apply the edge to the model.
  task automatic cycle();
    bit starve, ar, mr, ax, mx;
    #1;
    starve = (m_wait == MW);
    ar = starve ? !mdu_valid : 1'b1;
    mr = starve ? 1'b1 : !alu_valid;
    chk("alu_ready", 64'(alu_ready), 64'(ar));
    chk("mdu_ready", 64'(mdu_ready), 64'(mr));
    ax = alu_valid && ar;
    mx = mdu_valid && mr;
    @(posedge clk);
    if (ax) begin
      if (m_busy[alu_rd]) m_err = 1'b1;
      m_we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
    end else if (mx) begin
      if (mdu_rd != 0 && !m_busy[mdu_rd]) m_err = 1'b1;
      m_we = (mdu_rd != 0); m_waddr = mdu_rd; m_wdata = mdu_data;
    end else begin
      m_we = 1'b0;
    end
    if (mx) m_busy[mdu_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (!mdu_valid || mx) m_wait = 0;
    else if (m_wait < MW) m_wait++;
    last_ax = ax;
    last_mx = mx;
    #1;
    check_outputs("out");
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    model_reset();
    #1;
    chk("rst_we",    64'(rf_we),    64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_busy",  64'(busy_vec), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // ALU only
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
    cycle();
    chk("alu_we",    64'(rf_we),    64'd1);
    chk("alu_waddr", 64'(rf_waddr), 64'd3);
    chk("alu_wdata", 64'(rf_wdata), 64'h11);
    alu_valid = 0;
    cycle();
    chk("alu_we_off", 64'(rf_we), 64'd0);

    // Contention: MDU refused MW cycles, then wins
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hA5A5_0002;
    mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'hB00B_0009;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i < 4) chk("cont_alu_win", 64'(rf_waddr), 64'd2);
    end
    chk("cont_mdu_waddr", 64'(rf_waddr), 64'd9);
    chk("cont_mdu_wdata", 64'(rf_wdata), 64'hB00B_0009);
    mdu_valid = 1; mdu_rd = 5'd10; mdu_data = 32'hC0DE_000A;
    #1;
    chk("cont_cnt_cleared", 64'(mdu_ready), 64'd0);
    cycle();
    mdu_valid = 0;
    cycle();
    alu_valid = 0;

    // Scoreboard set / clear / set-wins
    issue_valid = 1; issue_rd = 5'd7;
    cycle();
    chk("sb_set7", 64'(busy_vec[7]), 64'd1);
    issue_valid = 0; mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h7777;
    cycle();
    chk("sb_clr7", 64'(busy_vec[7]), 64'd0);
    mdu_valid = 0; issue_valid = 1;
    cycle();
    mdu_valid = 1;
    cycle();
    chk("sb_setwins7", 64'(busy_vec[7]), 64'd1);
    issue_valid = 0;
    cycle();
    mdu_valid = 0;

    // Register $0
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    cycle();
    chk("r0_we", 64'(rf_we), 64'd0);
    alu_valid = 0; issue_valid = 1; issue_rd = 5'd0;
    cycle();
    chk("r0_busy", 64'(busy_vec), 64'(busy_word()));
    chk("r0_busy0", 64'(busy_vec[0]), 64'd0);
    issue_valid = 0;

    // Asynchronous reset mid-operation
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h4444;
    issue_valid = 1; issue_rd = 5'd12;
    cycle();
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_we",    64'(rf_we),    64'd0);
    chk("arst_waddr", 64'(rf_waddr), 64'd0);
    chk("arst_wdata", 64'(rf_wdata), 64'd0);
    chk("arst_busy",  64'(busy_vec), 64'd0);
    model_reset();
    set_idle();
    #1 reset = 1'b1;
    cycle();
    chk("post_rst_we", 64'(rf_we), 64'd0);

    // Randomized traffic, producers hold rd/data while refused
    for (int c = 0; c < 400; c++) begin
      if (!(alu_valid && !last_ax)) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = AW'($urandom_range(0, NR - 1));
        alu_data  = $urandom;
      end
      if (!(mdu_valid && !last_mx)) begin
        mdu_valid = ($urandom_range(0, 2) != 0);
        mdu_rd    = AW'($urandom_range(0, NR - 1));
        mdu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, NR - 1));
      cycle();
    end
    set_idle();
    cycle();

`ifdef RFWB_ERR_CHECK_EN
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    mdu_valid = 1; mdu_rd = 5'd5; mdu_data = 32'h5555;
    cycle();
    chk("err_set", 64'(err_sticky), 64'd1);
    mdu_valid = 0;
    cycle();
    cycle();
    chk("err_hold", 64'(err_sticky), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
